// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses 5A A5 CMD LEN_H LEN_L PAYLOAD[LEN] CHK frames
// from a UART byte stream into sequential payload write requests plus
// frame done / error pulses for the control state machine.
module uart_frame_parser #(
  parameter logic [7:0] HDR0        = 8'h5A,
  parameter logic [7:0] HDR1        = 8'hA5,
  parameter int         ADDR_W      = 18,
  parameter int         TIMEOUT_CYC = 520_000
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic [7:0]        o_cmd,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  // Each state names the byte the parser is waiting for.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H1   = 3'd1,
    S_CMD  = 3'd2,
    S_LENH = 3'd3,
    S_LENL = 3'd4,
    S_DATA = 3'd5,
    S_CHK  = 3'd6
  } state_t;

  logic [1:0]        rst_sync_q;
  logic              rst_n_s;

  state_t            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        lenh_q, lenh_d;
  logic [15:0]       rem_q, rem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        cmd_cur_q, cmd_cur_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              in_frame_s;

  // Reset synchronizer: assertion is immediate, release follows two clock edges.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  assign in_frame_s = (state_q == S_CMD) || (state_q == S_LENH) || (state_q == S_LENL) ||
                      (state_q == S_DATA) || (state_q == S_CHK);

  // Next-state, checksum, payload indexing and inter-byte timeout.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    lenh_d    = lenh_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    cmd_cur_d = cmd_cur_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (i_rx_done) begin
      // A byte always restarts the silence counter, so it beats a timeout on the same cycle.
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (i_rx_data == HDR0) begin
            state_d = S_H1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_H1: begin
          if (i_rx_data == HDR1) begin
            state_d = S_CMD;
            sum_d   = 8'h00;
          end else if (i_rx_data == HDR0) begin
            state_d = S_H1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          cmd_cur_d = i_rx_data;
          sum_d     = sum_q + i_rx_data;
          state_d   = S_LENH;
        end
        S_LENH: begin
          lenh_d  = i_rx_data;
          sum_d   = sum_q + i_rx_data;
          state_d = S_LENL;
        end
        S_LENL: begin
          sum_d = sum_q + i_rx_data;
          rem_d = {lenh_q, i_rx_data};
          idx_d = '0;
          if ({lenh_q, i_rx_data} != 16'd0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_CHK;
          end
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = i_rx_data;
          idx_d     = idx_q + ADDR_W'(1);
          rem_d     = rem_q - 16'd1;
          sum_d     = sum_q + i_rx_data;
          if (rem_q == 16'd1) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
        S_CHK: begin
          if (i_rx_data == sum_q) begin
            done_d = 1'b1;
            cmd_d  = cmd_cur_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (in_frame_s) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
    busy_d = (state_d == S_CMD) || (state_d == S_LENH) || (state_d == S_LENL) ||
             (state_d == S_DATA) || (state_d == S_CHK);
  end

  // Parser state and registered outputs.
  always_ff @(posedge i_clk_sys or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q   <= S_IDLE;
      sum_q     <= 8'h00;
      lenh_q    <= 8'h00;
      rem_q     <= 16'd0;
      idx_q     <= '0;
      cmd_cur_q <= 8'h00;
      tmo_q     <= '0;
      cmd_q     <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      lenh_q    <= lenh_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      cmd_cur_q <= cmd_cur_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign o_cmd        = cmd_q;
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_busy       = busy_q;

endmodule
